// File: rtl/pwm_capture.sv
// pwm_capture
//   Measures an external PWM/pulse input in the clk domain. Each complete
//   period (rise to rise) is reported as a period / high-time pair with a
//   one-cycle meas_valid strobe. An input with no edges for TIMEOUT cycles
//   raises timeout, and level holds the static input level at that point.
//
// Ports
//   clk        in   single clock domain
//   rst_n      in   asynchronous active-low reset
//   pwm_in     in   asynchronous PWM input (2-flop synchronized)
//   enable     in   low holds the block in IDLE (synchronous clear)
//   period     out  [CNT_W] cycles between consecutive detected rises
//   high_time  out  [CNT_W] cycles from a rise to the following fall
//   meas_valid out  one-cycle strobe: period/high_time updated
//   timeout    out  no edge seen for TIMEOUT cycles
//   level      out  synchronized input level captured on timeout
module pwm_capture #(
  parameter int unsigned CNT_W   = 24,
  parameter int unsigned TIMEOUT = 12_000_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pwm_in,
  input  logic             enable,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  output logic             timeout,
  output logic             level
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HIGH  = 2'd1,
    LOW   = 2'd2,
    STUCK = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  logic             s0, s1, prev;
  logic             rise, fall;
  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d, cnt_inc;
  logic [CNT_W-1:0] hi_lat, hi_lat_d;
  logic [CNT_W-1:0] period_d, high_time_d;
  logic             meas_valid_d, timeout_d, level_d;

  assign rise = s1 & ~prev;
  assign fall = ~s1 & prev;

  // Saturating increment: a fall landing exactly on cnt==TIMEOUT moves to
  // LOW without a timeout, so the count must not step past TIMEOUT there.
  assign cnt_inc = (cnt == TO_CNT) ? cnt : cnt + ONE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0   <= 1'b0;
      s1   <= 1'b0;
      prev <= 1'b0;
    end else begin
      s0   <= pwm_in;
      s1   <= s0;
      prev <= s1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      hi_lat     <= '0;
      period     <= '0;
      high_time  <= '0;
      meas_valid <= 1'b0;
      timeout    <= 1'b0;
      level      <= 1'b0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      hi_lat     <= hi_lat_d;
      period     <= period_d;
      high_time  <= high_time_d;
      meas_valid <= meas_valid_d;
      timeout    <= timeout_d;
      level      <= level_d;
    end
  end

  always_comb begin
    state_d      = state;
    cnt_d        = cnt;
    hi_lat_d     = hi_lat;
    period_d     = period;
    high_time_d  = high_time;
    meas_valid_d = 1'b0;
    level_d      = level;

    if (!enable) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state)
        IDLE: begin
          // cnt doubles as the idle timer; any edge restarts it
          if (rise) begin
            cnt_d   = ONE;
            state_d = HIGH;
          end else if (fall) begin
            cnt_d = ONE;
          end else if (cnt == TO_CNT) begin
            level_d = s1;
            state_d = STUCK;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        HIGH: begin
          if (fall) begin
            hi_lat_d = cnt;
            cnt_d    = cnt_inc;
            state_d  = LOW;
          end else if (cnt == TO_CNT) begin
            level_d = 1'b1;
            state_d = STUCK;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        LOW: begin
          if (rise) begin
            period_d     = cnt;
            high_time_d  = hi_lat;
            meas_valid_d = 1'b1;
            cnt_d        = ONE;
            state_d      = HIGH;
          end else if (cnt == TO_CNT) begin
            level_d = 1'b0;
            state_d = STUCK;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        STUCK: begin
          if (rise) begin
            cnt_d   = ONE;
            state_d = HIGH;
          end else if (fall) begin
            cnt_d   = '0;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    timeout_d = (state_d == STUCK);
  end

endmodule

// File: tb/tb_pwm_capture.sv
module tb_pwm_capture;

  localparam int unsigned CW = 8;
  localparam int TO = 100;

  logic          clk;
  logic          rst_n;
  logic          pwm_in;
  logic          enable;
  logic [CW-1:0] period;
  logic [CW-1:0] high_time;
  logic          meas_valid;
  logic          timeout;
  logic          level;

  pwm_capture #(.CNT_W(CW), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pwm_in     (pwm_in),
    .enable     (enable),
    .period     (period),
    .high_time  (high_time),
    .meas_valid (meas_valid),
    .timeout    (timeout),
    .level      (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
  endtask

  // Reference model: the detected-level stream is pwm_in delayed two
  // cycles; measurements are timestamp differences between detected edges.
  bit m_s0, m_s1, m_prev;
  int c;
  bit stuck, in_period, got_fall;
  int rise_t, anchor, hi_len;
  int e_period, e_high, e_mv, e_to, e_level;

  task automatic model_reset();
    m_s0 = 0; m_s1 = 0; m_prev = 0;
    c = 0; stuck = 0; in_period = 0; got_fall = 0;
    rise_t = 0; anchor = 1; hi_len = 0;
    e_period = 0; e_high = 0; e_mv = 0; e_to = 0; e_level = 0;
  endtask

  task automatic model_step();
    bit r, f;
    c++;
    r = m_s1 && !m_prev;
    f = !m_s1 && m_prev;
    e_mv = 0;
    if (!enable) begin
      stuck = 0; in_period = 0; anchor = c + 1;
    end else if (stuck) begin
      if (r) begin
        stuck = 0; in_period = 1; got_fall = 0; rise_t = c; anchor = c;
      end else if (f) begin
        stuck = 0; in_period = 0; anchor = c + 1;
      end
    end else if (r) begin
      if (in_period && got_fall) begin
        e_period = c - rise_t;
        e_high   = hi_len;
        e_mv     = 1;
      end
      in_period = 1; got_fall = 0; rise_t = c; anchor = c;
    end else if (f) begin
      if (in_period) begin
        got_fall = 1; hi_len = c - rise_t;
      end else begin
        anchor = c;
      end
    end else if (c - anchor >= TO) begin
      stuck = 1;
      e_level = !in_period ? int'(m_s1) : (got_fall ? 0 : 1);
    end
    e_to = stuck;
    m_prev = m_s1; m_s1 = m_s0; m_s0 = pwm_in;
  endtask

  task automatic check_outputs();
    check("period",     int'(period),     e_period);
    check("high_time",  int'(high_time),  e_high);
    check("meas_valid", int'(meas_valid), e_mv);
    check("timeout",    int'(timeout),    e_to);
    check("level",      int'(level),      e_level);
  endtask

  // Called at a negedge: drive, step the model at posedge, compare at negedge.
  task automatic tick(input logic pv, input logic en);
    pwm_in = pv;
    enable = en;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic seg(input logic pv, input int len, input logic en);
    for (int i = 0; i < len; i++) tick(pv, en);
  endtask

  task automatic run_pwm(input int hi, input int lo, input int n);
    for (int i = 0; i < n; i++) begin
      seg(1'b1, hi, 1'b1);
      seg(1'b0, lo, 1'b1);
    end
  endtask

  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n  = 1'b0;
    pwm_in = 1'b0;
    enable = 1'b1;
    model_reset();
    #2;
    check_outputs();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // steady 3 high / 7 low
    run_pwm(3, 7, 8);
    // duty change to 8 high / 2 low
    run_pwm(8, 2, 6);
    // stuck low, stuck high, then release
    seg(1'b0, 150, 1'b1);
    seg(1'b1, 150, 1'b1);
    seg(1'b0, 150, 1'b1);
    // minimum period
    run_pwm(1, 1, 10);
    // period of exactly TIMEOUT
    run_pwm(5, 95, 3);
    run_pwm(4, 6, 2);
    // enable dropped during HIGH for 5 cycles
    seg(1'b1, 2, 1'b1);
    seg(1'b1, 1, 1'b0);
    seg(1'b0, 4, 1'b0);
    seg(1'b0, 3, 1'b1);
    run_pwm(3, 7, 4);
    // async reset mid-LOW
    seg(1'b1, 3, 1'b1);
    seg(1'b0, 4, 1'b1);
    async_reset();
    run_pwm(3, 7, 4);

    // randomized periods, long low phases and enable drops
    for (int i = 0; i < 200; i++) begin
      int hi, lo;
      hi = $urandom_range(1, 12);
      lo = $urandom_range(1, 12);
      if ($urandom_range(0, 9) == 0) lo = $urandom_range(90, 110);
      if ($urandom_range(0, 19) == 0) seg(1'($urandom_range(0, 1)), $urandom_range(1, 6), 1'b0);
      if ($urandom_range(0, 39) == 0) async_reset();
      run_pwm(hi, lo, 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pwm_capture.md
# pwm_capture

Input-side counterpart to the on-chip PWM LED driver path. The block samples an external PWM or pulse signal in the `clk` domain, which is the 24 MHz internal-oscillator clock. Each complete period is reported as a cycle-accurate period and high-time pair, qualified by a one-cycle valid strobe. Stuck-high and stuck-low inputs (0 % and 100 % duty) are reported through a timeout flag and the static input level.

## Interface
Parameters:
- `CNT_W`, 24: width of the internal counter and of the measurement outputs.
- `TIMEOUT`, 12_000_000: count, in `clk` cycles, at which an edge-less input is declared stuck. Must satisfy 2 ≤ `TIMEOUT` ≤ 2^`CNT_W`−1.

Ports:
- `clk` input 1: single clock. All logic in the block is in this domain.
- `rst_n` input 1: asynchronous, active-low reset.
- `pwm_in` input 1: asynchronous PWM input, passed through a 2-flop synchronizer.
- `enable` input 1: when low, the block is held in IDLE (synchronous clear).
- `period` output `CNT_W`: cycles from one rising edge to the next rising edge.
- `high_time` output `CNT_W`: cycles from a rising edge to the following falling edge.
- `meas_valid` output 1: one-cycle strobe indicating `period` and `high_time` were updated this cycle.
- `timeout` output 1: input has shown no edge for `TIMEOUT` cycles.
- `level` output 1: synchronized input level, captured when `timeout` is set.

## Operation
- **Synchronizer:** `s0` → `s1`, plus a `prev` register of `s1`. All three reset to 0.
  - rise = `s1` & ~`prev`
  - fall = ~`s1` & `prev`
- **Counter `cnt`:**
  - Loads 1 in the cycle a rise is detected.
  - Otherwise increments each cycle while in HIGH or LOW.
- **FSM states:** IDLE, HIGH, LOW, STUCK. Reset state is IDLE.
- **IDLE:**
  - On rise: `cnt`←1, go to HIGH. No measurement is produced.
  - If no edge occurs, the idle counter reaches `TIMEOUT`: set `timeout`, set `level`←`s1`, go to STUCK.
- **HIGH:**
  - On fall: `hi_lat`←`cnt`, go to LOW.
  - When `cnt`==`TIMEOUT`: set `timeout`, set `level`←1, go to STUCK.
- **LOW:**
  - On rise: `period`←`cnt`, `high_time`←`hi_lat`, `meas_valid`←1, `cnt`←1, go to HIGH.
  - When `cnt`==`TIMEOUT`: set `timeout`, set `level`←0, go to STUCK.
- **STUCK:**
  - On rise: clear `timeout`, `cnt`←1, go to HIGH. No measurement, because the period is incomplete.
  - On fall: clear `timeout`, go to IDLE.
- **Resulting definitions:**
  - `period` = R2 − R, where R and R2 are the cycles in which consecutive rises are detected.
  - `high_time` = F − R, where F is the cycle in which the intervening fall is detected.
  - Minimum reportable values are `high_time`=1 and `period`=2.
- **Count width:** `cnt` never exceeds `TIMEOUT`, so no wrap-around is possible.
- **Holding outputs:** `period` and `high_time` hold their last values through timeout, STUCK, IDLE and `enable` low.
- **`enable` low:**
  - Next state is IDLE, `cnt`←0, `timeout`←0, `meas_valid`←0.
  - The synchronizer keeps running.
- **Reset (asserted at any time, including mid-measurement):**
  - State IDLE; `cnt`, `hi_lat`, `period` and `high_time` all 0.
  - `meas_valid`, `timeout` and `level` 0.
  - The first measurement after reset requires two rises.
- **Input limits:** input pulses shorter than one `clk` period may be lost. This is accepted behaviour, not a bug.

## Timing
- All outputs are registered.
- Rise of `pwm_in` sampled at `clk` edge k:
  - `s1` high after edge k+1.
  - Rise detected in the cycle after edge k+1.
  - `meas_valid`, `period` and `high_time` update at edge k+2.
- `meas_valid` is high for exactly one cycle per completed period. It is never asserted on two consecutive cycles.
- `timeout` sets at the clock edge where `cnt` equals `TIMEOUT`. That is `TIMEOUT` cycles after the last detected edge, ±1 cycle from IDLE entry.
- `timeout` clears at the edge where the next rise or fall is detected.
- Simultaneous events, in priority order:
  - `rst_n` low overrides everything else.
  - `enable` low overrides edges.
  - An edge overrides timeout in the same cycle: a rise when `cnt`==`TIMEOUT` in LOW produces a valid measurement with `period`=`TIMEOUT`.

## Test plan
Run with `TIMEOUT`=100 and `CNT_W`=8.

1. **Steady PWM:** `pwm_in` repeats 3 cycles high, 7 low.
   - No `meas_valid` after the first rise.
   - Every 10 cycles thereafter, `meas_valid` pulses with `period`=10 and `high_time`=3.
2. **Duty change:** switch the input to 8 high, 2 low.
   - The period that straddles the switch reports `high_time` from its own falling edge.
   - Subsequent reports are `period`=10, `high_time`=8.
3. **0 % / 100 %:** hold `pwm_in` low, then high, for 150 cycles each.
   - `timeout`=1 roughly 100 cycles after the last edge, with `level` equal to 0 and 1 respectively.
   - No `meas_valid` is raised.
   - The next edge clears `timeout`.
4. **Boundary pulses:**
   - Input of 1 high, 1 low gives `period`=2, `high_time`=1 on every period.
   - A low phase making `period`=100 exactly reports `period`=100, `high_time` correct, and `timeout` stays 0.
5. **`enable` / reset mid-period:**
   - Drop `enable` during HIGH for 5 cycles: `period` and `high_time` hold, and no strobe occurs until two further rises.
   - Assert `rst_n`=0 mid-LOW: all outputs are 0 immediately (asynchronously).
